// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter.
package i2c_arb_pkg;
   localparam int ADDR_W          = 7;
   localparam int DATA_W          = 8;
   localparam int NUM_REQ_DEF     = 4;
   localparam int TIMEOUT_CYC_DEF = 1024;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_ISSUE,
      ST_BUSY,
      ST_COMPLETE
   } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr_i wins.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] win_o
);
   int   idx;
   logic found;

   always_comb begin
      win_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_i) + k) % NUM_REQ;
         if (!found && req_i[idx]) begin
            win_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_controller among NUM_REQ requesters.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ     = NUM_REQ_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr_i,
   input  logic [DATA_W*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_rw_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic [DATA_W-1:0]         rd_data_o,
   output logic                      err_o,
   output logic [ADDR_W-1:0]         ctl_addr_o,
   output logic [DATA_W-1:0]         ctl_data_in_o,
   output logic                      ctl_rw_o,
   output logic                      ctl_enable_o,
   input  logic                      ctl_ready_i,
   input  logic                      ctl_write_done_i,
   input  logic                      ctl_data_rdy_i,
   input  logic [DATA_W-1:0]         ctl_data_out_i
);
   localparam int PTR_W = $clog2(NUM_REQ);

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [PTR_W-1:0]     win_idx_q, win_idx_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d, ptr_nxt;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 rw_q, rw_d;
   logic [DATA_W-1:0]    rd_data_q, rd_data_d;
   logic                 wr_prev_q, rdy_prev_q;
   logic                 wr_rise, rdy_rise;
   logic [NUM_REQ-1:0]   win;
   logic [PTR_W-1:0]     win_idx;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .win_o (win)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (win[i]) win_idx = PTR_W'(i);
   end

   assign wr_rise  = ctl_write_done_i & ~wr_prev_q;
   assign rdy_rise = ctl_data_rdy_i & ~rdy_prev_q;
   assign ptr_nxt  = (win_idx_q == PTR_W'(NUM_REQ-1)) ? '0 : win_idx_q + 1'b1;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            tmo_q, tmo_d;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      win_idx_d = win_idx_q;
      ptr_d     = ptr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      rw_d      = rw_q;
      rd_data_d = rd_data_q;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_d      = '0;
      tmo_d     = tmo_q;
`endif
      case (state_q)
         ST_IDLE: if (|req_i) state_d = ST_ARB;
         ST_ARB: begin
            if (|req_i) begin
               gnt_d     = win;
               win_idx_d = win_idx;
               addr_d    = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
               data_d    = req_data_i[int'(win_idx)*DATA_W +: DATA_W];
               rw_d      = req_rw_i[win_idx];
               state_d   = ST_ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
               tmo_d     = 1'b0;
`endif
            end else begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: if (!ctl_ready_i) state_d = ST_BUSY;
         ST_BUSY: begin
            // Only the completion strobe matching the latched direction counts.
            if (rw_q ? rdy_rise : wr_rise) begin
               if (rw_q) rd_data_d = ctl_data_out_i;
               gnt_d   = '0;
               ptr_d   = ptr_nxt;
               state_d = ST_COMPLETE;
            end
         end
         ST_COMPLETE: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
`ifdef I2C_ARB_TIMEOUT_EN
      if (state_q == ST_ISSUE || state_q == ST_BUSY) begin
         wd_d = wd_q + 1'b1;
         if (state_d != ST_COMPLETE && wd_q == WD_W'(TIMEOUT_CYC-1)) begin
            gnt_d   = '0;
            ptr_d   = ptr_nxt;
            tmo_d   = 1'b1;
            state_d = ST_COMPLETE;
         end
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         win_idx_q  <= '0;
         ptr_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         rw_q       <= 1'b0;
         rd_data_q  <= '0;
         wr_prev_q  <= 1'b0;
         rdy_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         win_idx_q  <= win_idx_d;
         ptr_q      <= ptr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rw_q       <= rw_d;
         rd_data_q  <= rd_data_d;
         wr_prev_q  <= ctl_write_done_i;
         rdy_prev_q <= ctl_data_rdy_i;
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_q  <= '0;
         tmo_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         tmo_q <= tmo_d;
      end
   end
   assign err_o = (state_q == ST_COMPLETE) & tmo_q;
`else
   assign err_o = 1'b0;
`endif

   // Enable and done decode straight from state so reset drops them immediately.
   always_comb begin
      done_o = '0;
      if (state_q == ST_COMPLETE) done_o[win_idx_q] = 1'b1;
   end

   assign ctl_enable_o  = (state_q == ST_ISSUE) || (state_q == ST_BUSY);
   assign gnt_o         = gnt_q;
   assign rd_data_o     = rd_data_q;
   assign ctl_addr_o    = addr_q;
   assign ctl_data_in_o = data_q;
   assign ctl_rw_o      = rw_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter; honours I2C_ARB_TIMEOUT_EN when defined.
module tb_i2c_bus_arbiter;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [7*N-1:0] req_addr = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_rw = '0;
   logic [N-1:0]   gnt, done;
   logic [7:0]     rd_data;
   logic           err;
   logic [6:0]     ctl_addr;
   logic [7:0]     ctl_data_in;
   logic           ctl_rw, ctl_en;
   logic           ctl_ready = 1'b1, ctl_wd = 1'b0, ctl_dr = 1'b0;
   logic [7:0]     ctl_dout = '0;

   always #5 clk = ~clk;

   i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_addr_i(req_addr),
      .req_data_i(req_data), .req_rw_i(req_rw), .gnt_o(gnt), .done_o(done),
      .rd_data_o(rd_data), .err_o(err), .ctl_addr_o(ctl_addr),
      .ctl_data_in_o(ctl_data_in), .ctl_rw_o(ctl_rw), .ctl_enable_o(ctl_en),
      .ctl_ready_i(ctl_ready), .ctl_write_done_i(ctl_wd),
      .ctl_data_rdy_i(ctl_dr), .ctl_data_out_i(ctl_dout)
   );

   typedef struct {
      int         idx;
      logic       rw;
      logic [7:0] rd;
      logic       err;
      logic [6:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0, n_pass = 0, ovl = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   task automatic push(input int idx, input logic rw, input logic [7:0] rd,
                       input logic e, input logic [6:0] a, input logic [7:0] d);
      exp_t x;
      x.idx = idx; x.rw = rw; x.rd = rd; x.err = e; x.addr = a; x.data = d;
      sb.push_back(x);
   endtask

   // Monitor: every done pulse is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if ($countones(gnt) > 1 || $countones(done) > 1) ovl++;
      if (err && done == '0) ovl++;
      if (done != '0) begin
         if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
         else begin
            mon_e = sb.pop_front();
            chk("done_onehot", 32'(done), 32'd1 << mon_e.idx);
            chk("done_err", 32'(err), 32'(mon_e.err));
            chk("done_addr", 32'(ctl_addr), 32'(mon_e.addr));
            chk("done_data", 32'(ctl_data_in), 32'(mon_e.data));
            chk("done_rw", 32'(ctl_rw), 32'(mon_e.rw));
            if (mon_e.rw) chk("done_rd_data", 32'(rd_data), 32'(mon_e.rd));
         end
      end
   end

   task automatic set_slot(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
      req_addr[7*i +: 7] = a;
      req_data[8*i +: 8] = d;
      req_rw[i]          = rw;
   endtask

   task automatic wait_gnt(output int cyc);
      cyc = 0;
      while (gnt == '0 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("gnt_seen", 32'(|gnt), 32'd1);
   endtask

   task automatic finish_txn(input logic rw, input logic [7:0] rdv);
      @(negedge clk) ctl_ready = 1'b0;
      @(negedge clk);
      if (rw) begin ctl_dout = rdv; ctl_dr = 1'b1; end
      else ctl_wd = 1'b1;
      @(negedge clk);
      ctl_dr = 1'b0; ctl_wd = 1'b0; ctl_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int cyc, n, bad;
      logic rw;
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_enable", 32'(ctl_en), 32'd0);
      chk("rst_ctl_fields", {17'd0, ctl_addr, ctl_data_in}, 32'd0);
      chk("rst_ctl_rw", 32'(ctl_rw), 32'd0);
      rst_n = 1'b1;

      // Request withdrawn before arbitration: no grant, no enable.
      @(negedge clk) req = 4'b0001;
      @(negedge clk) req = 4'b0000;
      repeat (3) begin
         @(negedge clk);
         chk("withdraw_gnt", 32'(gnt), 32'd0);
      end
      chk("withdraw_en", 32'(ctl_en), 32'd0);

      // Single write from requester 1; req fields changed after grant must not leak.
      @(negedge clk);
      set_slot(1, 7'h51, 8'hAA, 1'b0);
      req = 4'b0010;
      wait_gnt(cyc);
      chk("wr_gnt_latency", 32'(cyc), 32'd2);
      chk("wr_gnt", 32'(gnt), 32'b0010);
      chk("wr_ctl_addr", 32'(ctl_addr), 32'h51);
      chk("wr_ctl_data", 32'(ctl_data_in), 32'hAA);
      chk("wr_enable", 32'(ctl_en), 32'd1);
      req = 4'b0000;
      set_slot(1, 7'h22, 8'h33, 1'b1);
      push(1, 1'b0, 8'h00, 1'b0, 7'h51, 8'hAA);
      finish_txn(1'b0, 8'h00);

      // ptr now 2: requesters 0 and 3 compete, 3 must win.
      set_slot(0, 7'h10, 8'h01, 1'b0);
      set_slot(3, 7'h7F, 8'hFE, 1'b0);
      req = 4'b1001;
      wait_gnt(cyc);
      chk("ptr_gnt", 32'(gnt), 32'b1000);
      req = 4'b0000;
      push(3, 1'b0, 8'h00, 1'b0, 7'h7F, 8'hFE);
      finish_txn(1'b0, 8'h00);

      // Read from requester 0 with a stray write_done edge that must be ignored.
      set_slot(0, 7'h3C, 8'h00, 1'b1);
      req = 4'b0001;
      wait_gnt(cyc);
      chk("rd_gnt", 32'(gnt), 32'b0001);
      chk("rd_ctl_rw", 32'(ctl_rw), 32'd1);
      req = 4'b0000;
      @(negedge clk) ctl_ready = 1'b0;
      @(negedge clk) ctl_wd = 1'b1;
      @(negedge clk) ctl_wd = 1'b0;
      repeat (2) @(negedge clk);
      chk("wrong_edge_gnt", 32'(gnt), 32'b0001);
      chk("wrong_edge_en", 32'(ctl_en), 32'd1);
      push(0, 1'b1, 8'h5C, 1'b0, 7'h3C, 8'h00);
      @(negedge clk);
      ctl_dout = 8'h5C; ctl_dr = 1'b1;
      @(negedge clk);
      ctl_dr = 1'b0; ctl_ready = 1'b1;
      @(negedge clk) ctl_dout = 8'h00;
      repeat (3) @(negedge clk);
      chk("rd_data_hold", 32'(rd_data), 32'h5C);

      // Reset while BUSY: enable drops at once, no done, pointer back to 0.
      set_slot(2, 7'h12, 8'h34, 1'b0);
      req = 4'b0100;
      wait_gnt(cyc);
      chk("rst_case_gnt", 32'(gnt), 32'b0100);
      req = 4'b0000;
      @(negedge clk) ctl_ready = 1'b0;
      @(negedge clk);
      chk("busy_en", 32'(ctl_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_en", 32'(ctl_en), 32'd0);
      chk("async_rst_gnt", 32'(gnt), 32'd0);
      chk("async_rst_rd", 32'(rd_data), 32'd0);
      repeat (2) @(negedge clk);
      ctl_ready = 1'b1;
      for (int i = 0; i < N; i++) set_slot(i, 7'(7'h40 + i), 8'(8'h80 + i), 1'b0);
      req = 4'b1111;
      rst_n = 1'b1;

      // Contention with all requests held: order 0,1,2,3,0; last one is a read.
      for (int t = 0; t < 5; t++) begin
         wait_gnt(cyc);
         chk("rr_gnt", 32'(gnt), 32'd1 << (t % 4));
         if (t == 3) req_rw[0] = 1'b1;
         if (t == 4) req = 4'b0000;
         rw = (t == 4);
         push(t % 4, rw, 8'hC3, 1'b0, 7'(7'h40 + t % 4), 8'(8'h80 + t % 4));
         finish_txn(rw, 8'hC3);
      end

      // Controller never finishes.
      set_slot(2, 7'h2A, 8'hB5, 1'b1);
      req = 4'b0100;
      wait_gnt(cyc);
      chk("tmo_gnt", 32'(gnt), 32'b0100);
      req = 4'b0000;
`ifdef I2C_ARB_TIMEOUT_EN
      push(2, 1'b1, 8'hC3, 1'b1, 7'h2A, 8'hB5);
      @(negedge clk) ctl_ready = 1'b0;
      n = 1;
      @(posedge clk); #1;
      while (done == '0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("tmo_cycles", 32'(n), 32'd16);
      @(negedge clk) ctl_ready = 1'b1;
      repeat (2) @(negedge clk);
`else
      @(negedge clk) ctl_ready = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (gnt != 4'b0100 || err || !ctl_en) bad++;
      end
      chk("no_tmo_hold", 32'(bad), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      ctl_ready = 1'b1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
`endif
      chk("gnt_done_onehot", 32'(ovl), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit in clk cycles.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 req  in  NUM_REQ  per-requester transaction request, level.
REQ-007 req_addr  in  7*NUM_REQ  7-bit slave address per requester, slice i at [7i+6:7i].
REQ-008 req_data  in  8*NUM_REQ  write byte per requester, slice i at [8i+7:8i].
REQ-009 req_rw  in  NUM_REQ  0 = write, 1 = read.
REQ-010 gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-011 done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 rd_data  out  8  read byte, valid in the done cycle and held until the next capture.
REQ-013 err  out  1  one-cycle pulse coincident with done on watchdog expiry.
REQ-014 ctl_addr / ctl_data_in / ctl_rw / ctl_enable  out  7/8/1/1  drive i2c_controller addr, data_in, rw, enable.
REQ-015 ctl_ready / ctl_write_done / ctl_data_rdy  in  1 each; ctl_data_out  in  8  from i2c_controller.

Function
REQ-016 States SHALL be IDLE, ARB, ISSUE, BUSY, COMPLETE.
REQ-017 IDLE -> ARB when any req bit is high; otherwise stay.
REQ-018 ARB: round-robin winner selected starting at priority pointer ptr, registered into gnt; ARB -> ISSUE next cycle; gnt high 2 cycles after req.
REQ-019 ARB with no req still high (all withdrawn) SHALL return to IDLE with gnt all-zero.
REQ-020 ISSUE: ctl_addr/ctl_data_in/ctl_rw latched from winner's slice at ARB exit; ctl_enable = 1; -> BUSY on first cycle with ctl_ready = 0.
REQ-021 BUSY: ctl_enable held 1; write completes on rising edge of ctl_write_done, read on rising edge of ctl_data_rdy (edge detect, registered previous value).
REQ-022 Read completion SHALL capture ctl_data_out into rd_data in the same edge.
REQ-023 COMPLETE: ctl_enable = 0, done[winner] = 1 for exactly one cycle, gnt cleared, ptr = (winner+1) mod NUM_REQ; -> IDLE.
REQ-024 Requester dropping req while granted SHALL be ignored; transaction runs to completion.
REQ-025 Latched ctl_* fields SHALL not change during ISSUE/BUSY irrespective of req_* changes.
REQ-026 Completion edge of the wrong type (write_done during read) SHALL be ignored.
REQ-027 At most one gnt and one done bit SHALL be high at any cycle.

Reset
REQ-028 On rst low, asynchronously: state = IDLE, gnt = 0, done = 0, err = 0, rd_data = 0, ctl_enable = 0, ctl_addr/ctl_data_in/ctl_rw = 0, ptr = 0, watchdog = 0.
REQ-029 Reset mid-transaction SHALL drop ctl_enable immediately and produce no done pulse.

Configuration
REQ-030 Macro I2C_ARB_TIMEOUT_EN defined: watchdog counts cycles in ISSUE+BUSY; on reaching TIMEOUT_CYC -> COMPLETE with err = 1, rd_data unchanged.
REQ-031 Macro undefined: no watchdog logic, err tied 0, BUSY waits indefinitely.

Structure
REQ-032 Package i2c_arb_pkg SHALL hold the state enum, ADDR_W = 7, DATA_W = 8 and the default NUM_REQ/TIMEOUT_CYC constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot winner), combinational, instantiated once.

Verification
REQ-034 Single write: req[1]=1, addr 7'h51, data 8'hAA, rw 0 -> gnt = 4'b0010, ctl_addr 7'h51, ctl_data_in 8'hAA, one done[1] pulse after ctl_write_done rises, ptr = 2.
REQ-035 Single read: req[0], rw 1, model returns 8'h5C on data_rdy -> rd_data = 8'h5C in the done[0] cycle, err = 0.
REQ-036 Contention: req = 4'b1111 held, ptr 0 -> grant order 0,1,2,3,0 with no overlap of gnt bits.
REQ-037 Reset: rst low during BUSY -> ctl_enable = 0 the same cycle, no done, grant after release starts from requester 0.
REQ-038 With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYC = 16, controller never completes -> err and done[i] pulse together 16 cycles after ISSUE entry; without the macro, gnt held and err stays 0 for 100 cycles.
